mult16_share_sched: RTL and testbench
=====================================

# mult16_share_sched

Round-robin scheduler that shares one 16x16 multiplier datapath among NREQ requesters. The multiplier is any of the team's 16-bit 3-step configurations (exact or truncated, with any final adder), attached through the `mul_*` port group. The scheduler accepts one operand pair at a time through a valid/ready handshake and drives the registered operands into the multiplier. It waits a programmable number of cycles for the combinational multiplier and adder path to settle, captures the 33-bit product, and returns it tagged with the requester ID. It sits between the requesting engines (error-analysis sweepers, MAC front-ends) and the shared multiplier instance.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WAIT_CYC, 2, settle cycles allowed for the multiplier path (1..15)
- IDW, $clog2(NREQ), width of requester ID

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- req_valid  in  NREQ  per-requester operand valid
- req_x  in  16*NREQ  multiplicand; requester i occupies bits [16i+15:16i]
- req_y  in  16*NREQ  multiplier; same packing as req_x
- req_ready  out  NREQ  one-hot grant/accept strobe
- mul_x  out  16  registered operand to multiplier x
- mul_y  out  16  registered operand to multiplier y
- mul_prod  in  33  multiplier prod output (combinational from mul_x/mul_y)
- rsp_valid  out  1  result valid
- rsp_id  out  IDW  requester index of result
- rsp_prod  out  33  captured product
- rsp_ready  in  1  consumer accepts result
- busy  out  1  high in any state other than IDLE
- op_cnt  out  32  completed-operation counter

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if any req_valid bit is set, select the first set bit searching upward from ptr, wrapping modulo NREQ.
  - req_ready for the selected index is high combinationally in that cycle; all other bits are 0. req_ready is 0 in every other state.
  - On that edge: mul_x/mul_y <= the selected operands, rsp_id <= index, ptr <= (index+1) mod NREQ, cnt <= WAIT_CYC-1, go to WAIT.
- WAIT: if cnt==0, rsp_prod <= mul_prod, rsp_valid <= 1, go to RESP. Otherwise decrement cnt.
- RESP: rsp_valid, rsp_id and rsp_prod are held stable. When rsp_valid&&rsp_ready, clear rsp_valid, increment op_cnt (wraps at 2^32), go to IDLE.
- mul_x/mul_y hold their last operands until the next grant. They are not cleared after capture.
- A requester may drop req_valid before it is granted without penalty. Operands are sampled only on the accept edge.
- Only one operation is outstanding at a time. No new grant occurs in WAIT or RESP.
- Width rule: rsp_prod is the full 33-bit mul_prod, unmodified. No truncation or saturation is applied.

## Timing
- Reset (asynchronous, any state, including mid-WAIT or mid-RESP):
  - State, cnt, ptr go to IDLE/0.
  - req_ready, rsp_valid, busy = 0.
  - mul_x, mul_y, rsp_id, rsp_prod, op_cnt = 0.
  - Any in-flight operation is discarded with no response.
- Accept at edge T. rsp_valid rises after edge T+WAIT_CYC.
- The earliest next accept is the edge after the rsp handshake, so minimum spacing is WAIT_CYC+2 cycles with rsp_ready held high.
- rsp_ready high before rsp_valid is allowed. The handshake completes on the first edge where both are high.
- rsp_ready low stalls the FSM in RESP indefinitely. All outputs stay stable.
- All requesters valid at once produces a strict grant order ptr, ptr+1, …, wrapping. Each requester gets at most one grant per NREQ grants while others wait.
- busy = (state != IDLE), registered.

## Test plan
- Reset release, requester 0 only, x=3, y=5, rsp_ready=1, bench ties an exact multiplier model to mul_* → req_ready[0] pulses once. rsp_valid rises 3 edges later (WAIT_CYC=2) with rsp_id=0, rsp_prod=15. op_cnt=1.
- Requester 1: x=0xFFFF, y=0xFFFF → rsp_prod=0x0FFFE0001, rsp_id=1. Then x=0, y=0xFFFF → rsp_prod=0.
- All four requesters valid continuously after reset → grant sequence 0,1,2,3,0,… with grants exactly 4 cycles apart. Each rsp_id matches the preceding grant.
- rsp_ready held low 10 cycles during RESP → rsp_valid/rsp_id/rsp_prod stay constant, req_ready stays 0, busy=1. Raising rsp_ready completes the handshake in one edge.
- rst_n pulsed low mid-WAIT with requester 2 active → no rsp_valid for that operation. All outputs read 0 during reset. After release the first grant goes to the lowest valid index (ptr=0).
- WAIT_CYC=1 and WAIT_CYC=15 builds, single requester streaming → accept-to-rsp_valid latency of 2 and 16 cycles respectively. op_cnt counts every completed handshake.

Source files
------------

// File: rtl/mult16_share_sched.sv
// mult16_share_sched: round-robin scheduler sharing one external 16x16 multiplier among NREQ requesters
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/x/y       per-requester operand pairs (16 bits each, packed by index)
//   req_ready           one-hot accept strobe, combinational, IDLE only
//   mul_x/y, mul_prod   registered operands out, 33-bit settled product in
//   rsp_valid/id/prod   tagged result, held until rsp_ready
//   busy, op_cnt        not-idle flag, completed-operation counter
module mult16_share_sched #(
  parameter int NREQ = 4,
  parameter int WAIT_CYC = 2,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_x,
  input  logic [16*NREQ-1:0]   req_y,
  output logic [NREQ-1:0]      req_ready,
  output logic [15:0]          mul_x,
  output logic [15:0]          mul_y,
  input  logic [32:0]          mul_prod,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [32:0]          rsp_prod,
  input  logic                 rsp_ready,
  output logic                 busy,
  output logic [31:0]          op_cnt
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [IDW-1:0] ptr_q, ptr_d, rsp_id_q, rsp_id_d, sel, cand;
  logic [15:0] mul_x_q, mul_x_d, mul_y_q, mul_y_d;
  logic [32:0] rsp_prod_q, rsp_prod_d;
  logic rsp_valid_q, rsp_valid_d, busy_q, busy_d, found;
  logic [31:0] op_cnt_q, op_cnt_d;
  logic [15:0] x_a [NREQ];
  logic [15:0] y_a [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign x_a[g] = req_x[16*g +: 16];
    assign y_a[g] = req_y[16*g +: 16];
  end
  // scan downward so the last hit is the nearest set bit at or after ptr
  always_comb begin
    found = 1'b0;
    sel = '0;
    cand = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (req_valid[cand]) begin
        found = 1'b1;
        sel = cand;
      end
    end
  end
  assign req_ready = (rst_n && state_q == IDLE && found) ? NREQ'(1) << sel : '0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    mul_x_d = mul_x_q;
    mul_y_d = mul_y_q;
    rsp_id_d = rsp_id_q;
    rsp_prod_d = rsp_prod_q;
    rsp_valid_d = rsp_valid_q;
    op_cnt_d = op_cnt_q;
    case (state_q)
      IDLE: if (found) begin
        mul_x_d = x_a[sel];
        mul_y_d = y_a[sel];
        rsp_id_d = sel;
        ptr_d = (sel == IDW'(NREQ-1)) ? '0 : sel + 1'b1;
        cnt_d = 4'(WAIT_CYC-1);
        state_d = WAIT;
      end
      WAIT: if (cnt_q == '0) begin
        rsp_prod_d = mul_prod;
        rsp_valid_d = 1'b1;
        state_d = RESP;
      end else cnt_d = cnt_q - 1'b1;
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        op_cnt_d = op_cnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ptr_q <= '0;
      mul_x_q <= '0;
      mul_y_q <= '0;
      rsp_id_q <= '0;
      rsp_prod_q <= '0;
      rsp_valid_q <= 1'b0;
      busy_q <= 1'b0;
      op_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      mul_x_q <= mul_x_d;
      mul_y_q <= mul_y_d;
      rsp_id_q <= rsp_id_d;
      rsp_prod_q <= rsp_prod_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q <= busy_d;
      op_cnt_q <= op_cnt_d;
    end
  end
  assign mul_x = mul_x_q;
  assign mul_y = mul_y_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_prod = rsp_prod_q;
  assign busy = busy_q;
  assign op_cnt = op_cnt_q;
endmodule

// File: tb/tb_mult16_share_sched.sv
// tb_mult16_share_sched: scoreboard bench for mult16_share_sched with an exact multiplier on mul_*
module tb_mult16_share_sched #(parameter int WAIT_CYC = 2);
  localparam int NREQ = 4;
  localparam int IDW = 2;
  logic clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [16*NREQ-1:0] req_x = '0, req_y = '0;
  logic [15:0] mul_x, mul_y;
  logic [32:0] mul_prod, rsp_prod;
  logic rsp_valid, busy;
  logic [IDW-1:0] rsp_id;
  logic [31:0] op_cnt;
  int errors = 0, checks = 0;
  longint cyc = 0;
  bit spacing_chk = 0;
  typedef struct {int id; logic [32:0] prod; logic [15:0] x; logic [15:0] y; longint t;} exp_t;
  exp_t q[$];
  mult16_share_sched #(.NREQ(NREQ), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .mul_x(mul_x), .mul_y(mul_y), .mul_prod(mul_prod),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_prod(rsp_prod), .rsp_ready(rsp_ready),
    .busy(busy), .op_cnt(op_cnt));
  assign mul_prod = 33'(mul_x) * 33'(mul_y);
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
    end
  endfunction
  // reference model: one outstanding op, round-robin pick from a pointer
  int mptr = 0;
  bit outs = 0;
  longint lastg = -1;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_zero", 64'(|{req_ready, rsp_valid, busy, mul_x, mul_y, rsp_id, rsp_prod, op_cnt}), 0);
      q.delete();
      outs = 0;
      mptr = 0;
      lastg = -1;
    end else begin
      chk("busy", 64'(busy), 64'(outs));
      if (outs || req_valid == '0) begin
        chk("no_grant", 64'(req_ready), 0);
        if (outs && rsp_valid && rsp_ready) outs = 0;
      end else begin
        int g;
        logic [15:0] xs, ys;
        g = 0;
        for (int k = 0; k < NREQ; k++) if (req_valid[(mptr+k)%NREQ]) begin g = (mptr+k)%NREQ; break; end
        chk("grant", 64'(req_ready), 64'(1) << g);
        xs = req_x[g*16 +: 16];
        ys = req_y[g*16 +: 16];
        q.push_back('{id: g, prod: 33'(xs) * 33'(ys), x: xs, y: ys, t: cyc});
        if (spacing_chk && lastg >= 0) chk("grant_spacing", 64'(cyc - lastg), 64'(WAIT_CYC+2));
        lastg = spacing_chk ? cyc : -1;
        mptr = (g+1) % NREQ;
        outs = 1;
      end
    end
  end
  // monitor: latency on rise, hold while stalled, compare on handshake
  bit pv = 0, pr = 0;
  logic [IDW-1:0] pid;
  logic [32:0] pprod;
  int ops = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 0;
      ops = 0;
    end else begin
      if (rsp_valid && !pv) begin
        if (q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          chk("latency", 64'(cyc - q[0].t), 64'(WAIT_CYC+1));
          chk("mul_operands", {mul_x, mul_y}, {q[0].x, q[0].y});
        end
      end
      if (rsp_valid && pv && !pr) begin
        chk("hold_id", 64'(rsp_id), 64'(pid));
        chk("hold_prod", 64'(rsp_prod), 64'(pprod));
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) chk("rsp_no_expect", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_prod", 64'(rsp_prod), 64'(e.prod));
          chk("op_cnt", 64'(op_cnt), 64'(ops));
          ops++;
        end
      end
      pv = rsp_valid;
      pr = rsp_ready;
      pid = rsp_id;
      pprod = rsp_prod;
    end
  end
  task automatic issue(int i, logic [15:0] x, logic [15:0] y);
    req_x[i*16 +: 16] = x;
    req_y[i*16 +: 16] = y;
    req_valid[i] = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        return;
      end
    end
    chk("issue_timeout", 0, 1);
    req_valid[i] = 1'b0;
  endtask
  task automatic drain();
    repeat (WAIT_CYC+6) @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    issue(0, 16'd3, 16'd5);
    issue(1, 16'hFFFF, 16'hFFFF);
    issue(1, 16'h0000, 16'hFFFF);
    drain();
    req_x = {$urandom, $urandom};
    req_y = {$urandom, $urandom};
    req_valid = '1;
    spacing_chk = 1;
    for (int k = 0; k < 10*(WAIT_CYC+2); k++) begin
      logic [NREQ-1:0] gr;
      @(negedge clk);
      gr = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) if (gr[i]) begin
        req_x[i*16 +: 16] = 16'($urandom);
        req_y[i*16 +: 16] = 16'($urandom);
      end
    end
    req_valid = '0;
    spacing_chk = 0;
    drain();
    rsp_ready = 1'b0;
    issue(2, 16'($urandom), 16'($urandom));
    req_x[3*16 +: 16] = 16'h1234;
    req_y[3*16 +: 16] = 16'h00FF;
    req_valid[3] = 1'b1;
    begin
      bit seen = 0;
      for (int k = 0; k < 100 && !seen; k++) begin
        @(negedge clk);
        seen = rsp_valid;
      end
      if (!seen) chk("stall_wait_timeout", 0, 1);
    end
    repeat (10) @(posedge clk);
    #1 rsp_ready = 1'b1;
    issue(3, 16'h1234, 16'h00FF);
    drain();
    issue(2, 16'hBEEF, 16'h0101);
    #2 rst_n = 1'b0;
    req_x = {16'h0, 16'h0777, 16'h0033, 16'h0};
    req_y = {16'h0, 16'h0009, 16'h0044, 16'h0};
    req_valid = 4'b0110;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    begin
      bit seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        seen = req_ready != '0;
      end
      if (!seen) chk("post_reset_grant_timeout", 0, 1);
      @(posedge clk);
      #1 req_valid = '0;
    end
    drain();
    for (int k = 0; k < 400; k++) begin
      req_valid = NREQ'($urandom);
      req_x = {$urandom, $urandom};
      req_y = {$urandom, $urandom};
      rsp_ready = $urandom_range(0, 3) != 0;
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3*(WAIT_CYC+4)) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(q.size()), 0);
    chk("idle_at_end", 64'(busy), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
